// File: rtl/jam_param.sv
// jam_param: parametrised exhaustive job-assignment engine.
// Walks all N! worker->job permutations in lexicographic order. For each one
// it reads C[w][perm[w]] from an external combinational cost table and sums
// the entries. It reports the minimum total, how many permutations reach that
// total, and the first minimal permutation found. With PRUNE=1, a permutation
// is abandoned as soon as its partial sum is strictly greater than the current
// minimum.
// Ports:
//   CLK, RST      clock (rising edge) and asynchronous active-high reset
//   Start         run request, sampled only when idle or done
//   Busy          high while a run is in progress
//   W, J          cost-table lookup address (zero unless tallying)
//   Cost          table entry C[W][J], combinational
//   MinCost       minimum total cost
//   MatchCount    number of permutations at MinCost (saturating)
//   BestPerm      job of worker k at [k*IDX_W +: IDX_W]
//   Valid         results final, held while done
module jam_param #(
    parameter int N      = 8,
    parameter int IDX_W  = 3,
    parameter int COST_W = 7,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 4,
    parameter bit PRUNE  = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Start,
    output logic               Busy,
    output logic [IDX_W-1:0]   W,
    output logic [IDX_W-1:0]   J,
    input  logic [COST_W-1:0]  Cost,
    output logic [SUM_W-1:0]   MinCost,
    output logic [CNT_W-1:0]   MatchCount,
    output logic [N*IDX_W-1:0] BestPerm,
    output logic               Valid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TALLY = 3'd1,
        CMP   = 3'd2,
        PIVOT = 3'd3,
        SUCC  = 3'd4,
        SWAP  = 3'd5,
        REV   = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] K_ONE   = IDX_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

    // Packed identity permutation: worker k is assigned job k.
    function automatic logic [N*IDX_W-1:0] identity_perm();
        logic [N*IDX_W-1:0] p;
        p = {(N*IDX_W){1'b0}};
        for (int m = 0; m < N; m++) begin
            p[m*IDX_W +: IDX_W] = IDX_W'(m);
        end
        return p;
    endfunction

    state_t             state_r, state_next;
    logic [IDX_W-1:0]   perm_r [N];
    logic [IDX_W-1:0]   perm_next [N];
    logic [SUM_W-1:0]   sum_r, sum_next;
    logic [IDX_W-1:0]   k_r, k_next;
    logic [IDX_W-1:0]   piv_r, piv_next;
    logic [IDX_W-1:0]   succ_r, succ_next;
    logic [SUM_W-1:0]   min_r, min_next;
    logic [CNT_W-1:0]   cnt_r, cnt_next;
    logic [N*IDX_W-1:0] best_r, best_next;
    logic               valid_r, busy_r;

    logic               piv_found_s;
    logic [IDX_W-1:0]   piv_idx_s;
    logic [IDX_W-1:0]   succ_idx_s;
    logic [SUM_W-1:0]   add_s;
    logic [IDX_W-1:0]   w_s, j_s;

    // Pivot search: the last index whose element is smaller than its right neighbour.
    always_comb begin
        piv_found_s = 1'b0;
        piv_idx_s   = {IDX_W{1'b0}};
        for (int m = 0; m < N - 1; m++) begin
            piv_found_s = (perm_r[m] < perm_r[m+1]) ? 1'b1 : piv_found_s;
            piv_idx_s   = (perm_r[m] < perm_r[m+1]) ? IDX_W'(m) : piv_idx_s;
        end
    end

    // Successor search: the last index right of the pivot holding a larger job.
    always_comb begin
        succ_idx_s = piv_r;
        for (int m = 0; m < N; m++) begin
            succ_idx_s = ((m > int'(piv_r)) && (perm_r[m] > perm_r[piv_r])) ? IDX_W'(m) : succ_idx_s;
        end
    end

    // Next-state and datapath update for every state.
    always_comb begin
        state_next = state_r;
        perm_next  = perm_r;
        sum_next   = sum_r;
        k_next     = k_r;
        piv_next   = piv_r;
        succ_next  = succ_r;
        min_next   = min_r;
        cnt_next   = cnt_r;
        best_next  = best_r;
        w_s        = {IDX_W{1'b0}};
        j_s        = {IDX_W{1'b0}};
        add_s      = sum_r + SUM_W'(Cost);
        case (state_r)
            IDLE, DONE: begin
                if (Start) begin
                    for (int m = 0; m < N; m++) begin
                        perm_next[m] = IDX_W'(m);
                    end
                    sum_next   = {SUM_W{1'b0}};
                    k_next     = {IDX_W{1'b0}};
                    min_next   = SUM_MAX;
                    cnt_next   = {CNT_W{1'b0}};
                    state_next = TALLY;
                end else begin
                    state_next = state_r;
                end
            end
            TALLY: begin
                w_s = k_r;
                j_s = perm_r[k_r];
                // Strict compare: a tie with the current minimum must still be counted.
                if (PRUNE && (add_s > min_r)) begin
                    sum_next   = {SUM_W{1'b0}};
                    k_next     = {IDX_W{1'b0}};
                    state_next = PIVOT;
                end else begin
                    sum_next   = add_s;
                    k_next     = k_r + K_ONE;
                    state_next = (k_r == K_LAST) ? CMP : TALLY;
                end
            end
            CMP: begin
                if (sum_r < min_r) begin
                    min_next = sum_r;
                    cnt_next = CNT_ONE;
                    for (int m = 0; m < N; m++) begin
                        best_next[m*IDX_W +: IDX_W] = perm_r[m];
                    end
                end else if (sum_r == min_r) begin
                    cnt_next = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
                end else begin
                    cnt_next = cnt_r;
                end
                sum_next   = {SUM_W{1'b0}};
                k_next     = {IDX_W{1'b0}};
                state_next = PIVOT;
            end
            PIVOT: begin
                if (piv_found_s) begin
                    piv_next   = piv_idx_s;
                    state_next = SUCC;
                end else begin
                    state_next = DONE;
                end
            end
            SUCC: begin
                succ_next  = succ_idx_s;
                state_next = SWAP;
            end
            SWAP: begin
                perm_next[piv_r]  = perm_r[succ_r];
                perm_next[succ_r] = perm_r[piv_r];
                state_next        = REV;
            end
            REV: begin
                // Element m (m > pivot) takes its mirror within [pivot+1 .. N-1].
                for (int m = 0; m < N; m++) begin
                    perm_next[m] = (m > int'(piv_r)) ? perm_r[IDX_W'(N + int'(piv_r) - m)] : perm_r[m];
                end
                state_next = TALLY;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; Valid/Busy are registered from the next state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            for (int m = 0; m < N; m++) begin
                perm_r[m] <= IDX_W'(m);
            end
            sum_r   <= {SUM_W{1'b0}};
            k_r     <= {IDX_W{1'b0}};
            piv_r   <= {IDX_W{1'b0}};
            succ_r  <= {IDX_W{1'b0}};
            min_r   <= SUM_MAX;
            cnt_r   <= {CNT_W{1'b0}};
            best_r  <= identity_perm();
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next;
            perm_r  <= perm_next;
            sum_r   <= sum_next;
            k_r     <= k_next;
            piv_r   <= piv_next;
            succ_r  <= succ_next;
            min_r   <= min_next;
            cnt_r   <= cnt_next;
            best_r  <= best_next;
            valid_r <= (state_next == DONE);
            busy_r  <= (state_next != IDLE) && (state_next != DONE);
        end
    end

    assign W          = w_s;
    assign J          = j_s;
    assign Busy       = busy_r;
    assign Valid      = valid_r;
    assign MinCost    = min_r;
    assign MatchCount = cnt_r;
    assign BestPerm   = best_r;

endmodule

// File: tb/tb_jam_param.sv
// Testbench for jam_param: four instances (N=3, N=4 unpruned, N=4 pruned,
// N=5) checked against a brute-force tuple-enumeration reference model.
module tb_jam_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // N=3 instance
    logic st3, busy3, val3;
    logic [1:0] w3, j3;
    logic [6:0] cost3;
    logic [9:0] min3;
    logic [3:0] mc3;
    logic [5:0] bp3;
    logic [6:0] tab3 [3][3];
    assign cost3 = tab3[w3][j3];

    // N=4 instances sharing one table
    logic st4a, busy4a, val4a, st4b, busy4b, val4b;
    logic [1:0] w4a, j4a, w4b, j4b;
    logic [6:0] cost4a, cost4b;
    logic [9:0] min4a, min4b;
    logic [3:0] mc4a, mc4b;
    logic [7:0] bp4a, bp4b;
    logic [6:0] tab4 [4][4];
    assign cost4a = tab4[w4a][j4a];
    assign cost4b = tab4[w4b][j4b];

    // N=5 instance, all costs 1
    logic st5, busy5, val5;
    logic [2:0] w5, j5;
    logic [6:0] cost5;
    logic [9:0] min5;
    logic [3:0] mc5;
    logic [14:0] bp5;
    assign cost5 = (w5 < 3'd5 && j5 < 3'd5) ? 7'd1 : 7'd0;

    jam_param #(.N(3), .IDX_W(2), .COST_W(7), .SUM_W(10), .CNT_W(4), .PRUNE(1'b0)) u3 (
        .CLK(clk), .RST(rst), .Start(st3), .Busy(busy3), .W(w3), .J(j3), .Cost(cost3),
        .MinCost(min3), .MatchCount(mc3), .BestPerm(bp3), .Valid(val3));
    jam_param #(.N(4), .IDX_W(2), .COST_W(7), .SUM_W(10), .CNT_W(4), .PRUNE(1'b0)) u4a (
        .CLK(clk), .RST(rst), .Start(st4a), .Busy(busy4a), .W(w4a), .J(j4a), .Cost(cost4a),
        .MinCost(min4a), .MatchCount(mc4a), .BestPerm(bp4a), .Valid(val4a));
    jam_param #(.N(4), .IDX_W(2), .COST_W(7), .SUM_W(10), .CNT_W(4), .PRUNE(1'b1)) u4b (
        .CLK(clk), .RST(rst), .Start(st4b), .Busy(busy4b), .W(w4b), .J(j4b), .Cost(cost4b),
        .MinCost(min4b), .MatchCount(mc4b), .BestPerm(bp4b), .Valid(val4b));
    jam_param #(.N(5), .IDX_W(3), .COST_W(7), .SUM_W(10), .CNT_W(4), .PRUNE(1'b0)) u5 (
        .CLK(clk), .RST(rst), .Start(st5), .Busy(busy5), .W(w5), .J(j5), .Cost(cost5),
        .MinCost(min5), .MatchCount(mc5), .BestPerm(bp5), .Valid(val5));

    // Reference model state
    int m_n;
    int m_tab [5][5];
    int m_min, m_cnt, m_nperm;
    int m_best [5];
    int m_perms [120][5];

    // Enumerate every base-N tuple in ascending order (lexicographic), keep the permutations.
    task automatic ref_model(input int cnt_max);
        int total;
        total = 1;
        for (int i = 0; i < m_n; i++) total = total * m_n;
        m_min = 1 << 30;
        m_cnt = 0;
        m_nperm = 0;
        for (int code = 0; code < total; code++) begin
            int d [5];
            int rem, used, s;
            bit ok;
            rem = code;
            for (int k = m_n - 1; k >= 0; k--) begin
                d[k] = rem % m_n;
                rem = rem / m_n;
            end
            used = 0;
            ok = 1'b1;
            for (int k = 0; k < m_n; k++) begin
                if (used[d[k]]) ok = 1'b0;
                used = used | (1 << d[k]);
            end
            if (ok) begin
                s = 0;
                for (int k = 0; k < m_n; k++) begin
                    s = s + m_tab[k][d[k]];
                    m_perms[m_nperm][k] = d[k];
                end
                m_nperm++;
                if (s < m_min) begin
                    m_min = s;
                    m_cnt = 1;
                    for (int k = 0; k < m_n; k++) m_best[k] = d[k];
                end else if (s == m_min && m_cnt < cnt_max) begin
                    m_cnt++;
                end
            end
        end
    endtask

    function automatic int pack_best(input int idxw);
        int r;
        r = 0;
        for (int k = 0; k < m_n; k++) r = r | (m_best[k] << (k * idxw));
        return r;
    endfunction

    function automatic int exp_latency(input int n);
        int f;
        f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f * (n + 2) + (f - 1) * 3;
    endfunction

    task automatic set_start(input int id, input logic v);
        case (id)
            0: st3 = v;
            1: st4a = v;
            2: st4b = v;
            default: st5 = v;
        endcase
    endtask

    function automatic logic get_valid(input int id);
        case (id)
            0: return val3;
            1: return val4a;
            2: return val4b;
            default: return val5;
        endcase
    endfunction

    // Pulse Start, then count edges until Valid (lat = -1 on timeout).
    task automatic run_and_wait(input int id, input int budget, output int lat);
        @(negedge clk);
        set_start(id, 1'b1);
        @(posedge clk);
        #1;
        set_start(id, 1'b0);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (get_valid(id)) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic load_tab4_random();
        m_n = 4;
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < 4; j++) begin
                tab4[w][j] = 7'($urandom_range(127, 0));
                m_tab[w][j] = int'(tab4[w][j]);
            end
        end
        ref_model(15);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        st3 = 1'b0; st4a = 1'b0; st4b = 1'b0; st5 = 1'b0;
        for (int w = 0; w < 3; w++) for (int j = 0; j < 3; j++) tab3[w][j] = 7'd0;
        for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) tab4[w][j] = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy3, val3, w3, j3} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctl3: got busy=%b valid=%b w=%0d j=%0d, want all 0", busy3, val3, w3, j3);
        end
        n_cmp++;
        if (min3 !== 10'h3FF || mc3 !== 4'd0 || bp3 !== 6'h24) begin
            n_err++;
            $display("FAIL reset_res3: got min=%0h cnt=%0d bp=%0h, want 3ff 0 24", min3, mc3, bp3);
        end
        n_cmp++;
        if (min4a !== 10'h3FF || mc4a !== 4'd0 || bp4a !== 8'hE4 || val4a !== 1'b0 || busy4a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_res4: got min=%0h cnt=%0d bp=%0h v=%b b=%b, want 3ff 0 e4 0 0",
                     min4a, mc4a, bp4a, val4a, busy4a);
        end
    endtask

    task automatic test_products();
        int exp_w[$];
        int exp_j[$];
        m_n = 3;
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 3; j++) begin
                tab3[w][j] = 7'((w + 1) * (j + 1));
                m_tab[w][j] = (w + 1) * (j + 1);
            end
        end
        ref_model(15);
        // Expected lookup trace: N tally cycles, CMP, PIVOT, then SUCC/SWAP/REV between permutations.
        for (int p = 0; p < m_nperm; p++) begin
            for (int k = 0; k < 3; k++) begin
                exp_w.push_back(k);
                exp_j.push_back(m_perms[p][k]);
            end
            repeat ((p == m_nperm - 1) ? 2 : 5) begin
                exp_w.push_back(0);
                exp_j.push_back(0);
            end
        end
        @(negedge clk);
        st3 = 1'b1;
        @(posedge clk);
        #1;
        st3 = 1'b0;
        for (int c = 0; c < exp_w.size(); c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            n_cmp++;
            if (int'(w3) !== exp_w[c] || int'(j3) !== exp_j[c] || val3 !== 1'b0 || busy3 !== 1'b1) begin
                n_err++;
                $display("FAIL sweep3 cyc %0d: got w=%0d j=%0d v=%b b=%b, want w=%0d j=%0d v=0 b=1",
                         c, w3, j3, val3, busy3, exp_w[c], exp_j[c]);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (val3 !== 1'b1 || busy3 !== 1'b0) begin
            n_err++;
            $display("FAIL done3_at_45: got valid=%b busy=%b, want 1 0", val3, busy3);
        end
        n_cmp++;
        if (int'(min3) !== m_min || int'(mc3) !== m_cnt || int'(bp3) !== pack_best(2)) begin
            n_err++;
            $display("FAIL products_model: got min=%0d cnt=%0d bp=%0h, want %0d %0d %0h",
                     min3, mc3, bp3, m_min, m_cnt, pack_best(2));
        end
        n_cmp++;
        if (min3 !== 10'd10 || mc3 !== 4'd1 || bp3 !== 6'h06) begin
            n_err++;
            $display("FAIL products_const: got min=%0d cnt=%0d bp=%0h, want 10 1 06", min3, mc3, bp3);
        end
    endtask

    task automatic test_all_equal();
        int lat;
        m_n = 3;
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 3; j++) begin
                tab3[w][j] = 7'd5;
                m_tab[w][j] = 5;
            end
        end
        ref_model(15);
        run_and_wait(0, 100, lat);
        n_cmp++;
        if (lat !== exp_latency(3)) begin
            n_err++;
            $display("FAIL equal3_latency: got %0d, want %0d", lat, exp_latency(3));
        end
        n_cmp++;
        if (int'(min3) !== m_min || int'(mc3) !== m_cnt || int'(bp3) !== pack_best(2)) begin
            n_err++;
            $display("FAIL equal3_result: got min=%0d cnt=%0d bp=%0h, want %0d %0d %0h",
                     min3, mc3, bp3, m_min, m_cnt, pack_best(2));
        end
    endtask

    task automatic test_saturate();
        int lat;
        m_n = 5;
        for (int w = 0; w < 5; w++) for (int j = 0; j < 5; j++) m_tab[w][j] = 1;
        ref_model(15);
        run_and_wait(3, 2000, lat);
        n_cmp++;
        if (lat !== exp_latency(5)) begin
            n_err++;
            $display("FAIL sat5_latency: got %0d, want %0d", lat, exp_latency(5));
        end
        n_cmp++;
        if (int'(min5) !== m_min || int'(mc5) !== m_cnt || int'(bp5) !== pack_best(3) || busy5 !== 1'b0) begin
            n_err++;
            $display("FAIL sat5_result: got min=%0d cnt=%0d bp=%0h busy=%b, want %0d %0d %0h 0",
                     min5, mc5, bp5, busy5, m_min, m_cnt, pack_best(3));
        end
    endtask

    task automatic test_prune_random();
        int la, lb;
        for (int round = 0; round < 3; round++) begin
            load_tab4_random();
            @(negedge clk);
            st4a = 1'b1;
            st4b = 1'b1;
            @(posedge clk);
            #1;
            st4a = 1'b0;
            st4b = 1'b0;
            n_cmp++;
            if (busy4b !== 1'b1 || val4b !== 1'b0) begin
                n_err++;
                $display("FAIL prune_busy r%0d: got busy=%b valid=%b, want 1 0", round, busy4b, val4b);
            end
            la = -1;
            lb = -1;
            for (int c = 1; c <= 400; c++) begin
                @(posedge clk);
                #1;
                if (la < 0 && val4a) la = c;
                if (lb < 0 && val4b) lb = c;
                if (la >= 0 && lb >= 0) break;
            end
            n_cmp++;
            if (la !== exp_latency(4)) begin
                n_err++;
                $display("FAIL noprune_latency r%0d: got %0d, want %0d", round, la, exp_latency(4));
            end
            n_cmp++;
            if (lb <= 0 || lb >= la) begin
                n_err++;
                $display("FAIL prune_latency r%0d: got %0d, want 1..%0d", round, lb, la - 1);
            end
            n_cmp++;
            if (int'(min4a) !== m_min || int'(mc4a) !== m_cnt || int'(bp4a) !== pack_best(2)) begin
                n_err++;
                $display("FAIL noprune_result r%0d: got min=%0d cnt=%0d bp=%0h, want %0d %0d %0h",
                         round, min4a, mc4a, bp4a, m_min, m_cnt, pack_best(2));
            end
            n_cmp++;
            if (int'(min4b) !== m_min || int'(mc4b) !== m_cnt || int'(bp4b) !== pack_best(2)) begin
                n_err++;
                $display("FAIL prune_result r%0d: got min=%0d cnt=%0d bp=%0h, want %0d %0d %0h",
                         round, min4b, mc4b, bp4b, m_min, m_cnt, pack_best(2));
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        load_tab4_random();
        @(negedge clk);
        st4a = 1'b1;
        @(posedge clk);
        #1;
        st4a = 1'b0;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (val4a) begin
                lat = c;
                break;
            end
            st4a = (c >= 5 && c <= 60) ? 1'b1 : 1'b0;
        end
        st4a = 1'b0;
        n_cmp++;
        if (lat !== exp_latency(4)) begin
            n_err++;
            $display("FAIL busy_restart_latency: got %0d, want %0d", lat, exp_latency(4));
        end
        n_cmp++;
        if (int'(min4a) !== m_min || int'(mc4a) !== m_cnt || int'(bp4a) !== pack_best(2)) begin
            n_err++;
            $display("FAIL busy_restart_result: got min=%0d cnt=%0d bp=%0h, want %0d %0d %0h",
                     min4a, mc4a, bp4a, m_min, m_cnt, pack_best(2));
        end
    endtask

    task automatic test_restart_in_done();
        int lat;
        load_tab4_random();
        @(negedge clk);
        st4a = 1'b1;
        @(posedge clk);
        #1;
        st4a = 1'b0;
        n_cmp++;
        if (val4a !== 1'b0 || busy4a !== 1'b1) begin
            n_err++;
            $display("FAIL done_restart_edge: got valid=%b busy=%b, want 0 1", val4a, busy4a);
        end
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (val4a) begin
                lat = c;
                break;
            end
        end
        n_cmp++;
        if (lat !== exp_latency(4)) begin
            n_err++;
            $display("FAIL done_restart_latency: got %0d, want %0d", lat, exp_latency(4));
        end
        n_cmp++;
        if (int'(min4a) !== m_min || int'(mc4a) !== m_cnt || int'(bp4a) !== pack_best(2)) begin
            n_err++;
            $display("FAIL done_restart_result: got min=%0d cnt=%0d bp=%0h, want %0d %0d %0h",
                     min4a, mc4a, bp4a, m_min, m_cnt, pack_best(2));
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        load_tab4_random();
        @(negedge clk);
        st4a = 1'b1;
        @(posedge clk);
        #1;
        st4a = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy4a !== 1'b1 || w4a !== 2'd1) begin
            n_err++;
            $display("FAIL midrun_tally: got busy=%b w=%0d, want 1 1", busy4a, w4a);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy4a !== 1'b0 || val4a !== 1'b0 || w4a !== 2'd0 || j4a !== 2'd0 ||
            min4a !== 10'h3FF || mc4a !== 4'd0 || bp4a !== 8'hE4) begin
            n_err++;
            $display("FAIL midrun_reset: got b=%b v=%b w=%0d j=%0d min=%0h cnt=%0d bp=%0h, want 0 0 0 0 3ff 0 e4",
                     busy4a, val4a, w4a, j4a, min4a, mc4a, bp4a);
        end
        @(negedge clk);
        rst = 1'b0;
        run_and_wait(1, 400, lat);
        n_cmp++;
        if (lat !== exp_latency(4)) begin
            n_err++;
            $display("FAIL post_reset_latency: got %0d, want %0d", lat, exp_latency(4));
        end
        n_cmp++;
        if (int'(min4a) !== m_min || int'(mc4a) !== m_cnt || int'(bp4a) !== pack_best(2)) begin
            n_err++;
            $display("FAIL post_reset_result: got min=%0d cnt=%0d bp=%0h, want %0d %0d %0h",
                     min4a, mc4a, bp4a, m_min, m_cnt, pack_best(2));
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_all_equal();
        test_saturate();
        test_prune_random();
        test_start_while_busy();
        test_restart_in_done();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/jam_param.md
Name: jam_param

Overview:
- Parametrised job-assignment engine. Exhaustively enumerates all N! worker→job permutations in lexicographic order.
- For each permutation it accumulates cost by fetching every (worker, job) entry from an external cost table.
- Reports the minimum total cost, the number of permutations that reach it, and one optimal assignment.
- Successor of the fixed 8x8 engine: adds configurable N, widths, an optional branch-and-bound pruning mode, a Start/Busy handshake for repeated runs, and a best-permutation output.

Parameters:
- N, 8, number of workers = number of jobs (2..8).
- IDX_W, 3, width of worker/job index; 2^IDX_W >= N.
- COST_W, 7, width of one cost entry.
- SUM_W, 10, width of accumulated cost; must satisfy N*(2^COST_W-1) < 2^SUM_W.
- CNT_W, 4, width of MatchCount (saturating).
- PRUNE, 0, 1 = abort a permutation as soon as its partial sum exceeds the current MinCost.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Start  in  1  run request; sampled only in IDLE or DONE.
- Busy  out  1  high from the cycle after Start is accepted until DONE is entered.
- W  out  IDX_W  worker index for cost lookup.
- J  out  IDX_W  job index for cost lookup.
- Cost  in  COST_W  table entry C[W][J]; combinational, valid in the same cycle W/J are driven.
- MinCost  out  SUM_W  minimum total cost found.
- MatchCount  out  CNT_W  number of permutations with total == MinCost.
- BestPerm  out  N*IDX_W  job of worker k at bits [k*IDX_W +: IDX_W]; first minimum in lexicographic order.
- Valid  out  1  results final; held high in DONE.

Behaviour:
- Reset values: state=IDLE, Busy=0, Valid=0, W=0, J=0, MinCost=all-ones, MatchCount=0, BestPerm=identity, perm registers=identity, sum=0, worker counter=0.
- States:
  - IDLE: Start=1 → load identity perm, sum=0, k=0, MinCost=all-ones, MatchCount=0; go to TALLY.
  - TALLY: drive W=k, J=perm[k]; sum+=Cost; k++.
    - At k==N-1 → CMP.
    - PRUNE=1 and (sum+Cost) > MinCost → PIVOT; skip CMP, sum/k cleared.
  - CMP: sum<MinCost → MinCost=sum, MatchCount=1, BestPerm=perm. sum==MinCost → MatchCount+=1, saturating at 2^CNT_W-1. Otherwise no change. Clear sum and k; go to PIVOT.
  - PIVOT: i = largest index with perm[i]<perm[i+1]. None exists → DONE. Otherwise latch i; go to SUCC.
  - SUCC: j = largest index > i with perm[j]>perm[i]; go to SWAP.
  - SWAP: exchange perm[i] and perm[j]; go to REV.
  - REV: reverse perm[i+1..N-1] in one cycle; go to TALLY.
  - DONE: Valid=1, Busy=0, outputs held. Start=1 → same actions as in IDLE; Valid drops on that edge.
- W, J are 0 in every state except TALLY.
- Valid and Busy are registered: Valid == (state==DONE); Busy == (state not in {IDLE, DONE}).
- Start while Busy: ignored, no effect.
- Latency with PRUNE=0: each permutation costs N TALLY + 1 CMP + 1 PIVOT. Every non-last permutation costs 3 more (SUCC/SWAP/REV).
  - Total from Start-accept edge to DONE-entry edge = N!*(N+2) + (N!-1)*3.
- Pruning uses strict >, so ties still reach CMP and are counted. Results are identical to PRUNE=0; only cycle count differs.
- Arithmetic: sum and compare are unsigned SUM_W; no overflow is possible given the SUM_W rule.
- RST mid-run: immediate return to reset values; a run in progress is discarded.

Test Plan:
- N=3, C[w][j]=(w+1)*(j+1), PRUNE=0, Start pulse → Valid after exactly 6*5+5*3=45 edges; MinCost=10, MatchCount=1, BestPerm={2,1,0}; W/J sweep observed in lex perm order.
- N=3, all C=5 → MinCost=15, MatchCount=6, BestPerm=identity {0,1,2}.
- N=8, all C=1, CNT_W=4 → MinCost=8, MatchCount saturates at 15; Valid after 40320*10+40319*3 edges.
- N=4 random costs 0..127, PRUNE=1 vs PRUNE=0 against a software model → identical MinCost/MatchCount/BestPerm; PRUNE=1 reaches DONE in fewer cycles.
- Start asserted repeatedly while Busy → no restart. Start in DONE with a new table → Valid drops next edge, new correct results.
- RST pulsed mid-TALLY → all outputs at reset values next cycle, state IDLE; a subsequent Start produces correct results.
